cordic_linear_mult: RTL and testbench



---
 rtl/cordic_pkg.sv | 20 ++
 rtl/cordic_linear_step.sv | 38 +++
 rtl/cordic_linear_mult.sv | 170 +++++++++++++++++
 tb/tb_cordic_linear_mult.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cordic_pkg.sv
// Shared definitions for the linear-mode CORDIC blocks: default widths,
// Q16.16 constants, saturation limits and the multiplier FSM encoding.
package cordic_pkg;

   localparam int DEF_WIDTH = 32;
   localparam int DEF_FRAC  = 16;
   localparam int DEF_ITER  = 16;

   localparam logic [31:0] ONE     = 32'h0001_0000;
   localparam logic [31:0] MAX_POS = 32'h7FFF_FFFF;
   localparam logic [31:0] MIN_NEG = 32'h8000_0000;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ITER    = 2'd1,
      ST_RESCALE = 2'd2,
      ST_DONE    = 2'd3
   } state_t;

endpackage

// File: rtl/cordic_linear_step.sv
// One linear-mode CORDIC micro-rotation: steers y by +/- (xr >>> i) and
// drives zr toward zero by -/+ (ONE >> i).
module cordic_linear_step
   import cordic_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int FRAC  = DEF_FRAC,
   parameter int IW    = 4
) (
   input  logic [WIDTH-1:0] xr,
   input  logic [WIDTH-1:0] y,
   input  logic [WIDTH-1:0] zr,
   input  logic [IW-1:0]    i,
   output logic [WIDTH-1:0] y_next,
   output logic [WIDTH-1:0] zr_next
);

   localparam logic [WIDTH-1:0] ONE_W = {{(WIDTH-1){1'b0}}, 1'b1} << FRAC;

   logic             dir_pos;
   logic [WIDTH-1:0] x_sh;
   logic [WIDTH-1:0] one_sh;

   // Direction follows the sign of the residual multiplier; WIDTH-bit wrap.
   always_comb begin
      dir_pos = ~zr[WIDTH-1];
      x_sh    = $signed(xr) >>> i;
      one_sh  = ONE_W >> i;
      if (dir_pos) begin
         y_next  = y + x_sh;
         zr_next = zr - one_sh;
      end else begin
         y_next  = y - x_sh;
         zr_next = zr + one_sh;
      end
   end

endmodule

// File: rtl/cordic_linear_mult.sv
// Iterative linear-mode CORDIC multiplier: y = x*z by shift-add, then
// rescaled by 2^k with saturation to undo the upstream z normalization.
module cordic_linear_mult
   import cordic_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int FRAC  = DEF_FRAC,
   parameter int ITER  = DEF_ITER
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] x_in,
   input  logic [WIDTH-1:0] z_in,
   input  logic [WIDTH-1:0] count_div,
   output logic [WIDTH-1:0] result,
   output logic             overflow,
   output logic             busy,
   output logic             done
);

   localparam int IW = (ITER < 2) ? 1 : $clog2(ITER);
   localparam logic [IW-1:0]    LAST_I  = IW'(ITER - 1);
   localparam logic [IW-1:0]    I_ONE   = {{(IW-1){1'b0}}, 1'b1};
   localparam logic [WIDTH-1:0] K_ONE   = {{(WIDTH-1){1'b0}}, 1'b1};
   localparam logic [WIDTH-1:0] SAT_POS = {1'b0, {(WIDTH-1){1'b1}}};
   localparam logic [WIDTH-1:0] SAT_NEG = {1'b1, {(WIDTH-1){1'b0}}};

   state_t           state_q, state_d;
   logic [WIDTH-1:0] xr_q, xr_d;
   logic [WIDTH-1:0] y_q, y_d;
   logic [WIDTH-1:0] zr_q, zr_d;
   logic [WIDTH-1:0] kr_q, kr_d;
   logic [IW-1:0]    i_q, i_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic             overflow_q, overflow_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;

   logic [WIDTH-1:0] y_step;
   logic [WIDTH-1:0] zr_step;
   logic [WIDTH-1:0] y_dbl;
   logic             shift_ovf;

   function automatic logic [WIDTH-1:0] sat_value(input logic neg);
      if (neg) begin
         sat_value = SAT_NEG;
      end else begin
         sat_value = SAT_POS;
      end
   endfunction

   cordic_linear_step #(
      .WIDTH (WIDTH),
      .FRAC  (FRAC),
      .IW    (IW)
   ) u_step (
      .xr      (xr_q),
      .y       (y_q),
      .zr      (zr_q),
      .i       (i_q),
      .y_next  (y_step),
      .zr_next (zr_step)
   );

   // Next-state, datapath and registered-output logic for the FSM.
   always_comb begin
      state_d    = state_q;
      xr_d       = xr_q;
      y_d        = y_q;
      zr_d       = zr_q;
      kr_d       = kr_q;
      i_d        = i_q;
      result_d   = result_q;
      overflow_d = overflow_q;
      y_dbl      = y_q << 1;
      shift_ovf  = (y_q[WIDTH-1] != y_q[WIDTH-2]);

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               xr_d       = x_in;
               zr_d       = z_in;
               y_d        = '0;
               i_d        = '0;
               kr_d       = count_div;
               overflow_d = 1'b0;
               state_d    = ST_ITER;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_ITER: begin
            y_d  = y_step;
            zr_d = zr_step;
            i_d  = i_q + I_ONE;
            if (i_q == LAST_I) begin
               // Zero product or no halving to undo: rescale would be a no-op.
               if ((kr_q == '0) || (y_step == '0)) begin
                  result_d = y_step;
                  state_d  = ST_DONE;
               end else begin
                  state_d = ST_RESCALE;
               end
            end else begin
               state_d = ST_ITER;
            end
         end
         ST_RESCALE: begin
            if (shift_ovf) begin
               y_d        = sat_value(y_q[WIDTH-1]);
               result_d   = sat_value(y_q[WIDTH-1]);
               overflow_d = 1'b1;
               state_d    = ST_DONE;
            end else begin
               y_d  = y_dbl;
               kr_d = kr_q - K_ONE;
               if (kr_q == K_ONE) begin
                  result_d = y_dbl;
                  state_d  = ST_DONE;
               end else begin
                  state_d = ST_RESCALE;
               end
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      busy_d = (state_d != ST_IDLE);
      done_d = (state_d == ST_DONE);
   end

   // State and output registers with synchronous reset priority.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         xr_q       <= '0;
         y_q        <= '0;
         zr_q       <= '0;
         kr_q       <= '0;
         i_q        <= '0;
         result_q   <= '0;
         overflow_q <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         xr_q       <= xr_d;
         y_q        <= y_d;
         zr_q       <= zr_d;
         kr_q       <= kr_d;
         i_q        <= i_d;
         result_q   <= result_d;
         overflow_q <= overflow_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
      end
   end

   assign result   = result_q;
   assign overflow = overflow_q;
   assign busy     = busy_q;
   assign done     = done_q;

endmodule

// File: tb/tb_cordic_linear_mult.sv
// Scoreboard bench for cordic_linear_mult: driver pushes reference results,
// an independent monitor pops and compares on every done pulse.
module tb_cordic_linear_mult;
   import cordic_pkg::*;

   localparam int WIDTH = 32;
   localparam int ITER  = 16;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              start = 1'b0;
   logic [WIDTH-1:0]  x_in = '0;
   logic [WIDTH-1:0]  z_in = '0;
   logic [WIDTH-1:0]  count_div = '0;
   logic [WIDTH-1:0]  result;
   logic              overflow;
   logic              busy;
   logic              done;

   typedef struct {
      logic [31:0] x;
      logic [31:0] z;
      logic [31:0] k;
      logic [31:0] res;
      bit          ovf;
      int          lat;
      int          start_cyc;
      bit          tol_chk;
   } exp_t;

   exp_t sb_q[$];
   exp_t mon_e;
   exp_t last_e;
   int   errors = 0;
   int   checks = 0;
   int   cyc = 0;

   cordic_linear_mult #(.WIDTH(WIDTH), .FRAC(16), .ITER(ITER)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .x_in      (x_in),
      .z_in      (z_in),
      .count_div (count_div),
      .result    (result),
      .overflow  (overflow),
      .busy      (busy),
      .done      (done)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Reference: CORDIC recurrences in plain integer arithmetic, then 2^k
   // scaling where each doubling must keep the value within WIDTH-1 bits.
   function automatic void ref_model(input logic [31:0] x, input logic [31:0] z,
                                     input logic [31:0] k, output logic [31:0] res,
                                     output bit ovf, output int lat);
      logic signed [31:0] xs;
      logic signed [31:0] y;
      logic signed [31:0] zz;
      longint v;
      int j;
      xs = x;
      y  = 0;
      zz = z;
      for (int i = 0; i < ITER; i++) begin
         if (zz >= 0) begin
            y  = y + (xs >>> i);
            zz = zz - (32'sd65536 >>> i);
         end else begin
            y  = y - (xs >>> i);
            zz = zz + (32'sd65536 >>> i);
         end
      end
      v   = y;
      j   = 0;
      ovf = 1'b0;
      if (k != 0 && y != 0) begin
         while (longint'(j) < longint'(k) && !ovf) begin
            if (v > 64'sd1073741823 || v < -64'sd1073741824) ovf = 1'b1;
            else begin
               v = v * 2;
               j++;
            end
         end
      end
      if (ovf) res = (y < 0) ? MIN_NEG : MAX_POS;
      else     res = v[31:0];
      lat = ITER + j + (ovf ? 1 : 0);
   endfunction

   // Monitor: every done pulse must match the oldest outstanding request.
   always @(negedge clk) begin
      if (!rst && done) begin
         if (sb_q.size() == 0) begin
            errors++;
            checks++;
            $display("FAIL unexpected_done: result=%h with no request pending", result);
         end else begin
            mon_e = sb_q.pop_front();
            chk("result", result, mon_e.res);
            chk("overflow", {31'd0, overflow}, {31'd0, mon_e.ovf});
            chk("latency", cyc - mon_e.start_cyc, mon_e.lat);
            chk("busy_at_done", {31'd0, busy}, 32'd1);
            if (mon_e.tol_chk) begin
               real ideal, tol, diff;
               ideal = real'($signed(mon_e.x)) * real'($signed(mon_e.z)) / 65536.0
                       * real'(1 << mon_e.k);
               tol   = (real'($signed(mon_e.x) < 0 ? -$signed(mon_e.x) : $signed(mon_e.x))
                        / real'(1 << (ITER - 1)) + real'(ITER)) * real'(1 << mon_e.k);
               diff  = real'($signed(result)) - ideal;
               if (diff < 0.0) diff = -diff;
               checks++;
               if (diff > tol + 1.0e-6) begin
                  errors++;
                  $display("FAIL accuracy: got %0d ideal %f tolerance %f",
                           $signed(result), ideal, tol);
               end
            end
         end
      end
   end

   task automatic run_op(input logic [31:0] x, input logic [31:0] z, input logic [31:0] k,
                         input bit tol, input bit spam);
      exp_t e;
      int   n;
      bit   got;
      e.x = x;
      e.z = z;
      e.k = k;
      ref_model(x, z, k, e.res, e.ovf, e.lat);
      e.start_cyc = cyc + 1;
      e.tol_chk   = tol && !e.ovf && (k <= 32'd8);
      sb_q.push_back(e);
      last_e    = e;
      x_in      = x;
      z_in      = z;
      count_div = k;
      start     = 1'b1;
      @(negedge clk);
      start = 1'b0;
      n   = 0;
      got = 1'b0;
      while (n < ITER + WIDTH + 8) begin
         if (done) begin
            got = 1'b1;
            break;
         end
         if (spam && (n % 2 == 0)) begin
            start     = 1'b1;
            x_in      = $urandom;
            z_in      = $urandom;
            count_div = $urandom;
         end else begin
            start = 1'b0;
         end
         @(negedge clk);
         n++;
      end
      start = 1'b0;
      if (!got) begin
         errors++;
         checks++;
         $display("FAIL done_timeout: no done after %0d cycles, expected latency %0d", n, e.lat);
         sb_q.delete();
      end
      @(negedge clk);
   endtask

   task automatic check_hold();
      repeat (3) @(negedge clk);
      chk("hold_result", result, last_e.res);
      chk("hold_overflow", {31'd0, overflow}, {31'd0, last_e.ovf});
      chk("idle_busy", {31'd0, busy}, 32'd0);
   endtask

   initial begin
      int xs;
      int zs;
      logic [31:0] kk;

      repeat (3) @(negedge clk);
      chk("rst_result", result, 32'd0);
      chk("rst_overflow", {31'd0, overflow}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      rst = 1'b0;
      @(negedge clk);

      run_op(32'd98304, 32'd32768, 32'd0, 1'b1, 1'b0);
      check_hold();
      run_op(32'd65536, -32'sd98304, 32'd3, 1'b1, 1'b0);
      run_op(32'h4000_0000, 32'd65536, 32'd2, 1'b0, 1'b0);
      check_hold();
      run_op(-32'sh4000_0000, 32'd65536, 32'd2, 1'b0, 1'b0);
      run_op(32'd0, 32'd65536, 32'd20, 1'b0, 1'b0);
      run_op(32'd131072, 32'd49152, 32'd1, 1'b1, 1'b1);
      check_hold();
      // Saturating op immediately followed by a clean one: overflow must clear.
      run_op(32'h4000_0000, 32'd65536, 32'd5, 1'b0, 1'b0);
      run_op(32'd65536, 32'd65536, 32'd1, 1'b1, 1'b0);

      x_in      = 32'd65536;
      z_in      = 32'd65536;
      count_div = 32'd4;
      start     = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (5) @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      chk("midrst_busy", {31'd0, busy}, 32'd0);
      chk("midrst_done", {31'd0, done}, 32'd0);
      chk("midrst_result", result, 32'd0);
      chk("midrst_overflow", {31'd0, overflow}, 32'd0);
      rst = 1'b0;
      repeat (ITER + WIDTH + 4) @(negedge clk);

      for (int t = 0; t < 40; t++) begin
         xs = int'($urandom_range(0, 32'h0080_0000)) - 32'sh0040_0000;
         zs = int'($urandom_range(0, 262142)) - 131071;
         if ($urandom_range(0, 7) == 0) kk = $urandom_range(10, 40);
         else                            kk = $urandom_range(0, 6);
         run_op(xs, zs, kk, 1'b1, ($urandom_range(0, 3) == 0));
      end

      repeat (4) @(negedge clk);
      chk("queue_empty", sb_q.size(), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
